// File: rtl/mem_access_ctrl_pkg.sv
// Shared encodings for the memory access sequencer:
// opcodes, bus driver selects and FSM states.
package mem_access_ctrl_pkg;

  localparam int WCNT_W = 8;

  typedef enum logic [1:0] {
    OP_FETCH = 2'b00,
    OP_LOAD  = 2'b01,
    OP_STORE = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    BUS_MARMUX = 2'b00,
    BUS_PC     = 2'b01,
    BUS_ALU    = 2'b10,
    BUS_MDR    = 2'b11
  } bus_sel_e;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ADDR    = 3'd1,
    S_DATA_IN = 3'd2,
    S_WAIT    = 3'd3,
    S_XFER    = 3'd4,
    S_FIN     = 3'd5
  } state_e;

  function automatic logic is_read(input op_e op);
    return op != OP_STORE;
  endfunction

endpackage

// File: rtl/mem_access_ctrl.sv
// Memory access sequencer: drives MAR/MDR/IR/PC loads,
// bus select and memory enable for fetch, load and store.
module mem_access_ctrl #(
  parameter int WAIT_MAX = 15
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       START,
  input  logic [1:0] OP,
  input  logic       MEM_R,
  output logic [1:0] BUS_SEL,
  output logic       LD_MAR,
  output logic       LD_MDR,
  output logic       LD_IR,
  output logic       LD_PC,
  output logic       MIO_EN,
  output logic       R_W,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERR
);
  import mem_access_ctrl_pkg::*;

  localparam logic [WCNT_W-1:0] WLAST = WCNT_W'(WAIT_MAX - 1);

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [WCNT_W-1:0] cnt_q, cnt_d;
  logic              err_q, err_d;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
      op_q    <= OP_FETCH;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = '0;
    err_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (START) begin
          if (op_e'(OP) == OP_RSVD) begin
            err_d = 1'b1;
          end else begin
            op_d    = op_e'(OP);
            state_d = S_ADDR;
          end
        end
      end
      S_ADDR: begin
        state_d = (op_q == OP_STORE) ? S_DATA_IN : S_WAIT;
      end
      S_DATA_IN: state_d = S_WAIT;
      S_WAIT: begin
        if (MEM_R) begin
          state_d = (op_q == OP_FETCH) ? S_XFER : S_FIN;
        end else begin
          cnt_d = cnt_q + 1'b1;
          // Last tolerated wait cycle: give up, no DONE
          if (cnt_q == WLAST) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
          end
        end
      end
      S_XFER:  state_d = S_FIN;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    BUS_SEL = BUS_MARMUX;
    LD_MAR  = 1'b0;
    LD_MDR  = 1'b0;
    LD_IR   = 1'b0;
    LD_PC   = 1'b0;
    MIO_EN  = 1'b0;
    R_W     = 1'b0;
    BUSY    = state_q != S_IDLE;
    DONE    = state_q == S_FIN;
    ERR     = err_q;
    unique case (state_q)
      S_ADDR: begin
        LD_MAR = 1'b1;
        if (op_q == OP_FETCH) begin
          BUS_SEL = BUS_PC;
          LD_PC   = 1'b1;
        end
      end
      S_DATA_IN: begin
        BUS_SEL = BUS_ALU;
        LD_MDR  = 1'b1;
      end
      S_WAIT: begin
        MIO_EN = 1'b1;
        R_W    = op_q == OP_STORE;
        LD_MDR = is_read(op_q) & MEM_R;
      end
      S_XFER: begin
        BUS_SEL = BUS_MDR;
        LD_IR   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
